// File: rtl/melody_sequencer.sv
// Note-table melody sequencer with tempo/gap timing and a single priority sound-effect
// channel, producing a registered period/gate pair for the square-wave tone generator.
module melody_sequencer #(
    parameter int unsigned TICK_DIV = 251750,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned PERIOD_W = 18
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [$clog2(DEPTH)-1:0]  wr_addr,
    input  logic [PERIOD_W+3:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0]  seq_len,
    input  logic                      loop,
    input  logic [7:0]                tempo,
    input  logic [7:0]                gap,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      sfx_req,
    input  logic [PERIOD_W-1:0]       sfx_period,
    input  logic [7:0]                sfx_ticks,
    output logic                      sfx_ack,
    output logic [PERIOD_W-1:0]       tone_period,
    output logic                      tone_gate,
    output logic [$clog2(DEPTH)-1:0]  note_index,
    output logic                      busy,
    output logic                      done,
    output logic                      sfx_active
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {StIdle, StPlay} state_t;

    state_t                state;
    logic [PW-1:0]         presc;
    logic [11:0]           rem;
    logic [PERIOD_W-1:0]   mel_period;
    logic [7:0]            gap_q;
    logic [7:0]            sfx_cnt;
    logic [PERIOD_W-1:0]   sfx_period_q;
    logic [PERIOD_W+3:0]   note_mem [DEPTH];

    logic                  tick;
    logic                  start_ok;
    logic [IW-1:0]         next_idx;
    logic [PERIOD_W+3:0]   load_entry;
    logic [7:0]            tempo_eff;
    logic [4:0]            beats;
    logic [11:0]           load_total;
    logic                  mel_gate;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            note_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        tick       = (presc == PW'(TICK_DIV - 1));
        start_ok   = (state == StIdle) && start && !stop;
        // Entry to load next: 0 from IDLE or at sequence end, otherwise the following entry.
        next_idx   = ((state == StPlay) && (note_index != seq_len)) ? note_index + IW'(1) : '0;
        load_entry = note_mem[next_idx];
        tempo_eff  = (tempo == 8'd0) ? 8'd1 : tempo;
        beats      = {1'b0, load_entry[3:0]} + 5'd1;
        load_total = {7'b0, beats} * {4'b0, tempo_eff};
        mel_gate   = (state == StPlay) && (mel_period != '0) && (rem > {4'b0, gap_q});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= StIdle;
            presc        <= '0;
            rem          <= '0;
            mel_period   <= '0;
            gap_q        <= '0;
            note_index   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sfx_active   <= 1'b0;
            sfx_ack      <= 1'b0;
            sfx_cnt      <= '0;
            sfx_period_q <= '0;
            tone_period  <= '0;
            tone_gate    <= 1'b0;
        end else begin
            done    <= 1'b0;
            sfx_ack <= 1'b0;

            if (start_ok || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            if (stop) begin
                state <= StIdle;
                busy  <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (start) begin
                            rem        <= load_total;
                            mel_period <= load_entry[PERIOD_W+3:4];
                            gap_q      <= gap;
                            note_index <= '0;
                            busy       <= 1'b1;
                            state      <= StPlay;
                        end
                    end
                    StPlay: begin
                        if (tick) begin
                            if (rem == 12'd1) begin
                                if ((note_index != seq_len) || loop) begin
                                    rem        <= load_total;
                                    mel_period <= load_entry[PERIOD_W+3:4];
                                    gap_q      <= gap;
                                    note_index <= next_idx;
                                end else begin
                                    state <= StIdle;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                rem <= rem - 12'd1;
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end

            // Effect channel runs independently of the melody FSM; the melody keeps time underneath.
            if (!sfx_active) begin
                if (sfx_req) begin
                    sfx_ack      <= 1'b1;
                    sfx_active   <= 1'b1;
                    sfx_period_q <= sfx_period;
                    sfx_cnt      <= (sfx_ticks == 8'd0) ? 8'd1 : sfx_ticks;
                end
            end else if (tick) begin
                if (sfx_cnt == 8'd1) begin
                    sfx_active <= 1'b0;
                end else begin
                    sfx_cnt <= sfx_cnt - 8'd1;
                end
            end

            if (sfx_active) begin
                tone_period <= sfx_period_q;
                tone_gate   <= (sfx_period_q != '0);
            end else begin
                tone_period <= (state == StPlay) ? mel_period : '0;
                tone_gate   <= mel_gate;
            end
        end
    end

endmodule
